// File: rtl/poly_eval_engine.sv
// Multi-channel Horner polynomial evaluator with a saturating multiply-accumulate.
// Pops commands and coefficients from show-ahead FIFOs and pushes results with a status code.
module poly_eval_engine #(
  parameter int DW     = 16,
  parameter int RW     = 32,
  parameter int NCH    = 8,
  parameter int MAXDEG = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1+$clog2(NCH)+DW:0]     control_in,
  input  logic                          control_in_empty,
  output logic                          read_control,
  input  logic [DW-1:0]                 data_in,
  input  logic                          data_in_empty,
  output logic                          read_data,
  input  logic                          data_out_full,
  output logic                          write,
  output logic [RW-1:0]                 result,
  output logic [2:0]                    status,
  output logic                          error
);

  localparam int CW = $clog2(NCH);
  localparam int IW = $clog2(MAXDEG + 1);
  localparam int PW = RW + DW + 1;

  localparam logic signed [PW-1:0] HI = {{(DW+2){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [PW-1:0] LO = {{(DW+2){1'b1}}, {(RW-1){1'b0}}};

  localparam logic [1:0] OP_CLR   = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_EVAL  = 2'd2;
  localparam logic [1:0] OP_BURST = 2'd3;

  typedef enum logic [2:0] {
    IDLE, DECODE, LOAD, FETCHX, MAC, OUT
  } state_t;

  state_t state, next;

  logic [2+CW+DW-1:0] cmd;
  logic [NCH-1:0]     valid;
  logic [IW-1:0]      deg [NCH];
  logic [DW-1:0]      coef [NCH][MAXDEG+1];
  logic [IW-1:0]      idx;
  logic               first;
  logic               sat_f;
  logic [RW-1:0]      acc;
  logic [DW-1:0]      x;
  logic [DW-1:0]      rem;

  logic [1:0]    op;
  logic [CW-1:0] ch;
  logic [DW-1:0] arg;
  logic [IW-1:0] n_arg;
  logic [IW-1:0] cur_deg;
  logic          too_big;
  logic          ch_ok;
  logic          last_pop;
  logic          mac_last;

  assign op       = cmd[2+CW+DW-1 -: 2];
  assign ch       = cmd[DW +: CW];
  assign arg      = cmd[DW-1:0];
  assign n_arg    = arg[IW-1:0];
  assign cur_deg  = deg[ch];
  assign too_big  = arg > DW'(MAXDEG);
  assign ch_ok    = valid[ch];
  assign last_pop = idx == n_arg;
  assign mac_last = first ? (cur_deg == '0) : (idx == IW'(1));
  assign error    = status >= 3'd2;

  // Horner step: the first MAC cycle loads c_N, later cycles fold in c_(idx-1)
  logic [IW-1:0]        c_idx;
  logic [DW-1:0]        c_sel;
  logic [PW-1:0]        prod;
  logic signed [PW-1:0] sum;
  logic [RW-1:0]        acc_nx;
  logic                 step_sat;

  assign c_idx = first ? cur_deg : idx - IW'(1);
  assign c_sel = coef[ch][c_idx];

  always_comb begin
    prod     = {{(DW+1){acc[RW-1]}}, acc} * {{(RW+1){x[DW-1]}}, x};
    sum      = prod + {{(RW+1){c_sel[DW-1]}}, c_sel};
    acc_nx   = sum[RW-1:0];
    step_sat = 1'b0;
    if (first) begin
      acc_nx = {{(RW-DW){c_sel[DW-1]}}, c_sel};
    end else if (sum > HI) begin
      acc_nx   = {1'b0, {(RW-1){1'b1}}};
      step_sat = 1'b1;
    end else if (sum < LO) begin
      acc_nx   = {1'b1, {(RW-1){1'b0}}};
      step_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next         = state;
    read_control = 1'b0;
    read_data    = 1'b0;
    write        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!control_in_empty) begin
          read_control = 1'b1;
          next         = DECODE;
        end
      end
      DECODE: begin
        unique case (op)
          OP_CLR:   next = IDLE;
          OP_SET:   next = too_big ? OUT : LOAD;
          OP_EVAL:  next = ch_ok ? MAC : OUT;
          OP_BURST: next = (!ch_ok || arg == '0) ? OUT : FETCHX;
          default:  next = IDLE;
        endcase
      end
      LOAD: begin
        if (!data_in_empty) begin
          read_data = 1'b1;
          if (last_pop) next = IDLE;
        end
      end
      FETCHX: begin
        if (!data_in_empty) begin
          read_data = 1'b1;
          next      = MAC;
        end
      end
      MAC: begin
        if (mac_last) next = OUT;
      end
      OUT: begin
        if (!data_out_full) begin
          write = 1'b1;
          next  = (rem != '0) ? FETCHX : IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd    <= '0;
      valid  <= '0;
      idx    <= '0;
      first  <= 1'b0;
      sat_f  <= 1'b0;
      acc    <= '0;
      x      <= '0;
      rem    <= '0;
      result <= '0;
      status <= 3'd0;
      for (int i = 0; i < NCH; i++) deg[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!control_in_empty) cmd <= control_in;
        end
        DECODE: begin
          rem <= '0;
          unique case (op)
            OP_CLR: valid <= '0;
            OP_SET: begin
              if (too_big) begin
                result <= '0;
                status <= 3'd3;
              end else begin
                valid[ch] <= 1'b0;
                idx       <= '0;
              end
            end
            OP_EVAL: begin
              if (!ch_ok) begin
                result <= '0;
                status <= 3'd2;
              end else begin
                x     <= arg;
                idx   <= cur_deg;
                first <= 1'b1;
              end
            end
            OP_BURST: begin
              if (!ch_ok) begin
                result <= '0;
                status <= 3'd2;
              end else if (arg == '0) begin
                result <= '0;
                status <= 3'd4;
              end else begin
                rem <= arg;
              end
            end
            default: ;
          endcase
        end
        LOAD: begin
          if (!data_in_empty) begin
            idx <= idx + IW'(1);
            if (last_pop) begin
              valid[ch] <= 1'b1;
              deg[ch]   <= n_arg;
            end
          end
        end
        FETCHX: begin
          if (!data_in_empty) begin
            x     <= data_in;
            rem   <= rem - DW'(1);
            idx   <= cur_deg;
            first <= 1'b1;
          end
        end
        MAC: begin
          acc   <= acc_nx;
          first <= 1'b0;
          if (first) begin
            sat_f <= 1'b0;
          end else begin
            idx   <= idx - IW'(1);
            sat_f <= sat_f | step_sat;
          end
          if (mac_last) begin
            result <= acc_nx;
            status <= (!first && (sat_f || step_sat)) ? 3'd1 : 3'd0;
          end
        end
        OUT: ;
        default: ;
      endcase
    end
  end

  // Coefficient storage carries no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (state == LOAD && !data_in_empty) coef[ch][idx] <= data_in;
  end

endmodule
